lab4_branch_gshare_spec: RTL

LAB4_BRANCH_GSHARE_SPEC -- requirements
Module: lab4_branch_gshare_spec

---
 rtl/lab4_branch_pkg.sv | 22 ++
 rtl/lab4_branch_gshare_pht.sv | 44 ++++
 rtl/lab4_branch_gshare_spec.sv | 97 +++++++++
 3 files changed

// File: rtl/lab4_branch_pkg.sv
// Shared definitions for the gshare branch predictor: counter-width limits and
// the saturating counter step used by the pattern-history table.
package lab4_branch_pkg;

   localparam int unsigned CNT_BITS_MIN = 1;
   localparam int unsigned CNT_BITS_MAX = 4;

   // Saturating increment/decrement of an nbits-wide counter held in CNT_BITS_MAX bits.
   function automatic logic [CNT_BITS_MAX-1:0] sat_step(
      input logic [CNT_BITS_MAX-1:0] cnt,
      input logic                    inc,
      input int unsigned             nbits
   );
      logic [CNT_BITS_MAX-1:0] cmax;
      cmax = CNT_BITS_MAX'((32'd1 << nbits) - 32'd1);
      if (inc) begin
         return (cnt == cmax) ? cnt : cnt + 1'b1;
      end
      return (cnt == '0) ? cnt : cnt - 1'b1;
   endfunction

endpackage

// File: rtl/lab4_branch_gshare_pht.sv
// Pattern-history table: array of saturating counters with one combinational
// read port and one synchronous read-modify-write update port.
module lab4_branch_gshare_pht
   import lab4_branch_pkg::*;
#(
   parameter int unsigned PHT_SIZE  = 2048,
   parameter int unsigned CNT_BITS  = 2,
   parameter int unsigned PHT_NBITS = $clog2(PHT_SIZE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PHT_NBITS-1:0] rd_idx,
   output logic [CNT_BITS-1:0]  rd_cnt,
   input  logic                 wr_en,
   input  logic                 wr_taken,
   input  logic [PHT_NBITS-1:0] wr_idx
);

   localparam logic [CNT_BITS-1:0] CNT_RESET = CNT_BITS'((32'd1 << (CNT_BITS - 1)) - 32'd1);

   logic [CNT_BITS-1:0] cnt_q [PHT_SIZE];
   logic [CNT_BITS-1:0] cnt_d [PHT_SIZE];

   // Only the addressed counter moves; reads see the pre-edge value.
   always_comb begin
      cnt_d = cnt_q;
      if (wr_en) begin
         cnt_d[wr_idx] = CNT_BITS'(sat_step(CNT_BITS_MAX'(cnt_q[wr_idx]), wr_taken, CNT_BITS));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(PHT_SIZE); i++) begin
            cnt_q[i] <= CNT_RESET;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/lab4_branch_gshare_spec.sv
// Gshare branch predictor with speculative global history and mispredict repair.
// Optional statistics counters are built when LAB4_BRANCH_GSHARE_STATS_EN is defined.
module lab4_branch_gshare_spec
   import lab4_branch_pkg::*;
#(
   parameter int unsigned PHT_SIZE  = 2048,
   parameter int unsigned CNT_BITS  = 2,
   parameter int unsigned HIST_BITS = 11,
   parameter int unsigned PHT_NBITS = $clog2(PHT_SIZE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pred_val,
   input  logic [31:0]          pred_pc,
   output logic                 pred_taken,
   output logic [PHT_NBITS-1:0] pred_idx,
   output logic [HIST_BITS-1:0] pred_ghr,
   input  logic                 upd_en,
   input  logic                 upd_taken,
   input  logic [PHT_NBITS-1:0] upd_idx,
   input  logic [HIST_BITS-1:0] upd_ghr,
   input  logic                 upd_mispred,
   output logic [31:0]          stat_npred,
   output logic [31:0]          stat_nmispred
);

   logic [HIST_BITS-1:0] spec_ghr_q, spec_ghr_d;
   logic [CNT_BITS-1:0]  rd_cnt;
   logic                 repair;
   logic                 unused_pc_bits;

   assign unused_pc_bits = ^{pred_pc[31:PHT_NBITS+2], pred_pc[1:0]};

   assign pred_idx   = PHT_NBITS'(spec_ghr_q) ^ pred_pc[PHT_NBITS+1:2];
   assign pred_ghr   = spec_ghr_q;
   assign pred_taken = ~reset & rd_cnt[CNT_BITS-1];
   assign repair     = upd_en & upd_mispred;

   lab4_branch_gshare_pht #(
      .PHT_SIZE  (PHT_SIZE),
      .CNT_BITS  (CNT_BITS),
      .PHT_NBITS (PHT_NBITS)
   ) u_pht (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (pred_idx),
      .rd_cnt   (rd_cnt),
      .wr_en    (upd_en),
      .wr_taken (upd_taken),
      .wr_idx   (upd_idx)
   );

   // Truncating cast drops the oldest bit, and degenerates cleanly for HIST_BITS=1.
   always_comb begin
      spec_ghr_d = spec_ghr_q;
      if (repair) begin
         spec_ghr_d = HIST_BITS'({upd_ghr, upd_taken});
      end else if (pred_val) begin
         spec_ghr_d = HIST_BITS'({spec_ghr_q, pred_taken});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         spec_ghr_q <= '0;
      end else begin
         spec_ghr_q <= spec_ghr_d;
      end
   end

`ifdef LAB4_BRANCH_GSHARE_STATS_EN
   logic [31:0] npred_q, npred_d;
   logic [31:0] nmispred_q, nmispred_d;

   always_comb begin
      npred_d    = npred_q + 32'(pred_val);
      nmispred_d = nmispred_q + 32'(repair);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         npred_q    <= '0;
         nmispred_q <= '0;
      end else begin
         npred_q    <= npred_d;
         nmispred_q <= nmispred_d;
      end
   end

   assign stat_npred    = npred_q;
   assign stat_nmispred = nmispred_q;
`else
   assign stat_npred    = '0;
   assign stat_nmispred = '0;
`endif

endmodule
